axi_lite_cmd_master: RTL

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_lite_cmd_master.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master. Each command becomes one AW/W/B or AR/R
// transaction, and the slave's answer is returned on the rsp_* handshake.
module axi_lite_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESET,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,

    output logic                    busy,

    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,

    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,

    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,

    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;
    localparam logic [2:0] S_RSP          = 3'd5;

    logic [2:0]            state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q,      busy_d;
    logic                  awvalid_q,   awvalid_d;
    logic                  wvalid_q,    wvalid_d;
    logic                  bready_q,    bready_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  rready_q,    rready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,     wstrb_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q,  rsp_resp_d;
    logic                  rsp_write_q, rsp_write_d;

    logic                  aw_done_c;
    logic                  w_done_c;

    // State and output registers; reset leaves the block idle and ready.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    // Next-state logic; handshake-style outputs are decoded from the next state
    // so that every AXI output leaves a flop.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;
        arvalid_d   = arvalid_q;
        aw_done_c   = 1'b0;
        w_done_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        state_d   = S_WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // AW and W complete independently; leave once both have fired.
            S_WR_ADDR_DATA: begin
                aw_done_c = !awvalid_q || M_AXI_AWREADY;
                w_done_c  = !wvalid_q  || M_AXI_WREADY;
                if (awvalid_q && M_AXI_AWREADY) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && M_AXI_WREADY) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done_c && w_done_c) begin
                    state_d = S_WR_RESP;
                end
            end

            S_WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    state_d     = S_RSP;
                end
            end

            S_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_DATA;
                end
            end

            S_RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rsp_rdata_d = M_AXI_RDATA;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_write_d = 1'b0;
                    state_d     = S_RSP;
                end
            end

            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d   = S_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        bready_d    = (state_d == S_WR_RESP);
        rready_d    = (state_d == S_RD_DATA);
        rsp_valid_d = (state_d == S_RSP);
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_write     = rsp_write_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
